vga_scan_engine: RTL and testbench
==================================

VGA_SCAN_ENGINE -- requirements
Module: vga_scan_engine

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48: horizontal front porch, sync and back porch, in pixels.
REQ-003 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 Parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33: vertical front porch, sync and back porch, in lines.
REQ-005 Parameter COLOR_W, default 3: colour bits per pixel (3 gives 1-bit r/g/b).
REQ-006 Parameter SYNC_NEG, default 1: 1 means hsync and vsync are active-low.
REQ-007 Port clk, input, 1: single system clock, rising edge.
REQ-008 Port resetn, input, 1: reset; synchronous, active-low.
REQ-009 Port pix_ce, input, 1: pixel-clock enable; all timing state advances only on clk edges where pix_ce=1.
REQ-010 Port rgb_in, input, COLOR_W: pixel colour for the coordinate currently on line/offset.
REQ-011 Port line, output, clog2(V_ACTIVE+V_FP+V_SYNC+V_BP): current vertical count.
REQ-012 Port offset, output, clog2(H_ACTIVE+H_FP+H_SYNC+H_BP): current horizontal count.
REQ-013 Port color, output, COLOR_W: registered pixel to the DAC.
REQ-014 Ports hsync and vsync, output, 1 each: registered sync outputs, polarity per SYNC_NEG.
REQ-015 Port de, output, 1: registered display-enable.
REQ-016 Port frame_start, output, 1: one-clk pulse.
REQ-017 Port line_start, output, 1: one-clk pulse.

Function
REQ-018 Horizontal FSM states: H_ACT, H_FRONT, H_SYNC, H_BACK. Each state lasts H_ACTIVE, H_FP, H_SYNC and H_BP pix_ce ticks respectively, visited in that order; H_BACK wraps to H_ACT.
REQ-019 Vertical FSM states: V_ACT, V_FRONT, V_SYNC, V_BACK. It advances only on the tick where offset wraps from H_TOTAL-1 to 0, with region lengths per the V_* parameters.
REQ-020 offset counts 0..H_TOTAL-1 and wraps to 0; line counts 0..V_TOTAL-1, increments on an offset wrap, and wraps to 0 after V_TOTAL-1.
REQ-021 line and offset are driven directly from the counters, with zero latency.
REQ-022 color, hsync, vsync and de are updated on pix_ce ticks and lag line/offset by exactly one pix_ce tick.
REQ-023 de=1 iff the prior tick was in H_ACT and V_ACT.
REQ-024 color = rgb_in when de=1, else all zeros.
REQ-025 hsync is asserted iff the prior tick was in H_SYNC; vsync is asserted iff the prior tick was in V_SYNC.
REQ-026 line_start pulses for one clk on the tick where offset becomes 0.
REQ-027 frame_start pulses for one clk on the tick where both line and offset become 0.
REQ-028 With pix_ce=0, all counters and registered outputs hold, and line_start/frame_start are 0.
REQ-029 Any region parameter set to 0 is skipped; H_ACTIVE, V_ACTIVE, H_SYNC and V_SYNC shall be >=1, checked at elaboration.

Reset
REQ-030 resetn=0 at a clk edge forces offset=0, line=0, both FSMs to *_ACT, color=0, de=0, line_start=0 and frame_start=0, and hsync/vsync to their inactive level; this holds even mid-line and irrespective of pix_ce.
REQ-031 On the first pix_ce tick after resetn returns to 1, offset becomes 1 and frame_start does not pulse.

Configuration
REQ-032 Macro VGA_FB_ADDR_EN, when defined, adds output fb_addr, clog2(H_ACTIVE*V_ACTIVE) bits.
REQ-033 fb_addr is a linear framebuffer address equal to line*H_ACTIVE+offset during active video, held otherwise, and reset to 0.
REQ-034 fb_addr is built incrementally, with no multiplier.
REQ-035 fb_addr wraps to 0 when line returns to 0.
REQ-036 When VGA_FB_ADDR_EN is undefined, the port and its logic are absent and all other behaviour is identical.

Structure
REQ-037 Shared package vga_pkg holds the h_state_t and v_state_t enums, the 640x480@60 default timing constants, and a clog2 helper function.
REQ-038 One sub-module, vga_axis_counter, is instantiated twice (horizontal and vertical). It is parametrised by four region lengths, takes an advance enable, and outputs count, region state and wrap.

Verification
REQ-039 Use small timing: H 8/2/3/1 (H_TOTAL=14), V 4/1/2/1 (V_TOTAL=8), pix_ce=1. Expect de high for 8 of every 14 ticks on lines 0-3 only, hsync low on ticks 10-12 of each line (offset 11-13 at the output), and vsync low for lines 5-6.
REQ-040 Drive pix_ce as a 1,0,1,0 pattern. Expect each count to take two clks, all outputs to hold on pix_ce=0 clks, and one frame to last 224 clks.
REQ-041 Drive rgb_in=3'b101 constantly. Expect color=101 exactly when de=1 and 000 during porches/sync, with color lagging offset by 1 tick.
REQ-042 Pulse resetn=0 for one clk at line=2, offset=5. Expect the next cycle to show line=0, offset=0, de=0, hsync=vsync=1, and the scan to restart with no frame_start on the restart tick.
REQ-043 Run a full frame. Expect frame_start once per 112 ticks at line=0/offset=0, and line_start 8 times per frame.
REQ-044 With VGA_FB_ADDR_EN defined, expect fb_addr 0..31 sequentially over the active pixels, held at 7 through the line-0 blanking, and 0 on the next frame.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared scan-state types, 640x480@60 default timing and a clog2 helper
package vga_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam logic [1:0] R_ACT   = 2'd0;
  localparam logic [1:0] R_FRONT = 2'd1;
  localparam logic [1:0] R_SYNC  = 2'd2;
  localparam logic [1:0] R_BACK  = 2'd3;
  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNC, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNC, V_BACK} v_state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one scan axis -- count, region and wrap over four regions
// Ports: clk, resetn (sync, active-low), adv (advance enable),
//        count (current position), state (R_ACT..R_BACK), wrap (advancing from last count)
module vga_axis_counter import vga_pkg::*; #(
  parameter int R0 = 1,
  parameter int R1 = 0,
  parameter int R2 = 1,
  parameter int R3 = 0,
  parameter int W  = clog2(R0 + R1 + R2 + R3)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         adv,
  output logic [W-1:0] count,
  output logic [1:0]   state,
  output logic         wrap
);
  localparam int TOTAL = R0 + R1 + R2 + R3;
  logic [W-1:0] count_q, count_d;
  assign wrap  = adv && (count_q == W'(TOTAL - 1));
  assign count = count_q;
  // Region decoded from the count; zero-length regions never match, so they are skipped.
  always_comb begin
    count_d = !adv ? count_q : wrap ? '0 : count_q + 1'b1;
    state   = (int'(count_q) < R0)           ? R_ACT   :
              (int'(count_q) < R0 + R1)      ? R_FRONT :
              (int'(count_q) < R0 + R1 + R2) ? R_SYNC  : R_BACK;
  end
  always_ff @(posedge clk) begin
    count_q <= !resetn ? '0 : count_d;
  end
endmodule

// File: rtl/vga_scan_engine.sv
// vga_scan_engine: VGA raster timing with registered colour/sync/de outputs
// Ports: clk, resetn (sync, active-low), pix_ce (pixel enable), rgb_in (pixel for line/offset),
//        line/offset (live counters), color/hsync/vsync/de (one tick behind line/offset),
//        line_start/frame_start (one-clk pulses), fb_addr (only with VGA_FB_ADDR_EN defined)
module vga_scan_engine import vga_pkg::*; #(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int COLOR_W  = 3,
  parameter int SYNC_NEG = 1
) (
  input  logic                                            clk,
  input  logic                                            resetn,
  input  logic                                            pix_ce,
  input  logic [COLOR_W-1:0]                              rgb_in,
  output logic [clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]     line,
  output logic [clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]     offset,
  output logic [COLOR_W-1:0]                              color,
  output logic                                            hsync,
  output logic                                            vsync,
  output logic                                            de,
`ifdef VGA_FB_ADDR_EN
  output logic [clog2(H_ACTIVE*V_ACTIVE)-1:0]             fb_addr,
`endif
  output logic                                            line_start,
  output logic                                            frame_start
);
  localparam int HW = clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic SYNC_IDLE = logic'(SYNC_NEG != 0);
  if (H_ACTIVE < 1 || V_ACTIVE < 1 || H_SYNC < 1 || V_SYNC < 1) begin : g_bad_cfg
    $error("vga_scan_engine: H_ACTIVE, V_ACTIVE, H_SYNC and V_SYNC must be >= 1");
  end
  logic [1:0] h_raw, v_raw;
  logic h_wrap, v_wrap, act;
  h_state_t h_state;
  v_state_t v_state;
  logic [COLOR_W-1:0] color_q, color_d;
  logic hs_q, hs_d, vs_q, vs_d, de_q, de_d, ls_q, ls_d, fs_q, fs_d;
  vga_axis_counter #(.R0(H_ACTIVE), .R1(H_FP), .R2(H_SYNC), .R3(H_BP), .W(HW)) u_h (
    .clk(clk), .resetn(resetn), .adv(pix_ce), .count(offset), .state(h_raw), .wrap(h_wrap)
  );
  // The vertical axis steps only when the horizontal axis wraps on a pixel tick.
  vga_axis_counter #(.R0(V_ACTIVE), .R1(V_FP), .R2(V_SYNC), .R3(V_BP), .W(VW)) u_v (
    .clk(clk), .resetn(resetn), .adv(h_wrap), .count(line), .state(v_raw), .wrap(v_wrap)
  );
  assign h_state = h_state_t'(h_raw);
  assign v_state = v_state_t'(v_raw);
  assign act     = (h_state == vga_pkg::H_ACT) && (v_state == vga_pkg::V_ACT);
  always_comb begin
    de_d    = pix_ce ? act : de_q;
    color_d = pix_ce ? (act ? rgb_in : '0) : color_q;
    hs_d    = pix_ce ? ((h_state == vga_pkg::H_SYNC) ^ SYNC_IDLE) : hs_q;
    vs_d    = pix_ce ? ((v_state == vga_pkg::V_SYNC) ^ SYNC_IDLE) : vs_q;
    ls_d    = h_wrap;
    fs_d    = v_wrap;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      color_q <= '0;
      hs_q    <= SYNC_IDLE;
      vs_q    <= SYNC_IDLE;
      de_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      color_q <= color_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end
  assign color       = color_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
`ifdef VGA_FB_ADDR_EN
  // base_q is the address of pixel 0 on the current line, accumulated by H_ACTIVE
  // per active line; last_q remembers the most recent active address for blanking.
  localparam int AW = clog2(H_ACTIVE * V_ACTIVE);
  logic [AW-1:0] base_q, base_d, last_q, last_d, addr;
  assign addr = base_q + AW'(offset);
  always_comb begin
    base_d = v_wrap ? '0 : (h_wrap && v_state == vga_pkg::V_ACT) ? base_q + AW'(H_ACTIVE) : base_q;
    last_d = (pix_ce && act) ? addr : last_q;
  end
  always_ff @(posedge clk) begin
    base_q <= !resetn ? '0 : base_d;
    last_q <= !resetn ? '0 : last_d;
  end
  assign fb_addr = act ? addr : last_q;
`endif
endmodule

// File: tb/tb_vga_scan_engine.sv
// tb_vga_scan_engine: scoreboard bench for vga_scan_engine on a 14x8 raster
module tb_vga_scan_engine;
  typedef struct packed {
    logic [2:0] line;
    logic [3:0] offset;
    logic [2:0] color;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic [4:0] fb;
  } obs_t;
  logic clk = 1'b0, resetn = 1'b0, pix_ce = 1'b0;
  logic [2:0] rgb_in = 3'b000;
  logic [2:0] line;
  logic [3:0] offset;
  logic [2:0] color;
  logic hsync, vsync, de, line_start, frame_start;
  logic [4:0] fbv;
`ifdef VGA_FB_ADDR_EN
  logic [4:0] fb_addr;
  assign fbv = fb_addr;
`else
  assign fbv = 5'd0;
`endif
  obs_t q[$];
  obs_t m, e, a;
  int total = 0, bad = 0;
  int n_fs = 0, n_ls = 0, n_de = 0, n_col = 0, n_hl = 0, n_vl = 0;
  int b_fs, b_ls, b_de, b_col, b_hl, b_vl;
  int mx = 0, my = 0, mlast = 0;
  always #5 clk = ~clk;
  vga_scan_engine #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .COLOR_W(3), .SYNC_NEG(1)
  ) dut (
    .clk(clk), .resetn(resetn), .pix_ce(pix_ce), .rgb_in(rgb_in),
    .line(line), .offset(offset), .color(color),
    .hsync(hsync), .vsync(vsync), .de(de),
`ifdef VGA_FB_ADDR_EN
    .fb_addr(fb_addr),
`endif
    .line_start(line_start), .frame_start(frame_start)
  );
  // Drive one clk of inputs and queue the outputs expected right after that edge.
  task automatic step(input logic rn, input logic ce, input logic [2:0] rgb);
    logic act;
    @(negedge clk);
    resetn = rn;
    pix_ce = ce;
    rgb_in = rgb;
    if (!rn) begin
      mx = 0; my = 0; mlast = 0;
      m = '0; m.hs = 1'b1; m.vs = 1'b1;
    end else if (ce) begin
      act     = (mx < 8) && (my < 4);
      m.de    = act;
      m.color = act ? rgb : 3'b000;
      m.hs    = !(mx >= 10 && mx <= 12);
      m.vs    = !(my >= 5 && my <= 6);
      m.ls    = (mx == 13);
      m.fs    = (mx == 13) && (my == 7);
      if (mx == 13) begin
        mx = 0;
        my = (my == 7) ? 0 : my + 1;
      end else mx++;
    end else begin
      m.ls = 1'b0;
      m.fs = 1'b0;
    end
    m.line   = 3'(my);
    m.offset = 4'(mx);
`ifdef VGA_FB_ADDR_EN
    if (mx < 8 && my < 4) mlast = my * 8 + mx;
    m.fb = 5'(mlast);
`else
    m.fb = 5'd0;
`endif
    q.push_back(m);
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {line, offset, color, hsync, vsync, de, line_start, frame_start, fbv};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL scan t=%0t got line=%0d off=%0d col=%b hs=%b vs=%b de=%b ls=%b fs=%b fb=%0d want line=%0d off=%0d col=%b hs=%b vs=%b de=%b ls=%b fs=%b fb=%0d",
                 $time, a.line, a.offset, a.color, a.hs, a.vs, a.de, a.ls, a.fs, a.fb,
                 e.line, e.offset, e.color, e.hs, e.vs, e.de, e.ls, e.fs, e.fb);
      end
      n_fs  += int'(frame_start);
      n_ls  += int'(line_start);
      n_de  += int'(de);
      n_col += int'(color == 3'b101);
      n_hl  += int'(!hsync);
      n_vl  += int'(!vsync);
    end
  end
  task automatic mark();
    b_fs = n_fs; b_ls = n_ls; b_de = n_de; b_col = n_col; b_hl = n_hl; b_vl = n_vl;
  endtask
  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask
  task automatic settle();
    @(posedge clk);
    #2;
  endtask
  initial begin
    repeat (3) step(1'b0, 1'b0, 3'b000);
    mark();
    for (int i = 0; i < 112; i++) step(1'b1, 1'b1, 3'b101);
    settle();
    chk("A frame_start", n_fs - b_fs, 1);
    chk("A line_start", n_ls - b_ls, 8);
    chk("A de_clks", n_de - b_de, 32);
    chk("A color101_clks", n_col - b_col, 32);
    chk("A hsync_low_clks", n_hl - b_hl, 24);
    chk("A vsync_low_clks", n_vl - b_vl, 28);
    mark();
    for (int i = 0; i < 224; i++) step(1'b1, (i % 2) == 0, 3'b101);
    settle();
    chk("B frame_start", n_fs - b_fs, 1);
    chk("B line_start", n_ls - b_ls, 8);
    chk("B de_clks", n_de - b_de, 64);
    chk("B color101_clks", n_col - b_col, 64);
    chk("B hsync_low_clks", n_hl - b_hl, 48);
    chk("B vsync_low_clks", n_vl - b_vl, 56);
    mark();
    for (int i = 0; i < 33; i++) step(1'b1, 1'b1, 3'(i));
    step(1'b0, 1'b1, 3'b111);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 3'(i + 3));
    step(1'b0, 1'b0, 3'b010);
    step(1'b1, 1'b0, 3'b010);
    step(1'b1, 1'b0, 3'b010);
    step(1'b1, 1'b1, 3'b011);
    settle();
    chk("C frame_start_after_reset", n_fs - b_fs, 0);
    chk("C line_start_count", n_ls - b_ls, 3);
    for (int i = 0; i < 250; i++) step(1'b1, (i % 3) != 2, 3'(i * 3));
    repeat (2) settle();
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
